accumulator_bank: RTL and testbench
===================================

Name: accumulator_bank

Overview:
- Parametrised accumulator storage for the systolic array output path: NO_VECTORS rows x VECTOR_WIDTH lanes x DATA_WIDTH bits.
- Each write either overwrites a row or adds into it through a 2-stage read-modify-write pipeline with forwarding.
- A separate read port has valid/ready and 1-cycle latency.
- A clear FSM sweeps all rows after reset or on request, so the array needs no per-bit reset.

Parameters:
- VECTOR_WIDTH, 16, lanes per row.
- NO_VECTORS, 64, number of rows; must be a power of 2 and >= 2.
- DATA_WIDTH, 32, lane width; lanes are two's-complement signed.
- VECTOR_SELECTOR_WIDTH, $clog2(NO_VECTORS), row index width; derived, do not override.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- ASYNC_RST  in  1  reset, asynchronous, active-low.
- ClearReq  in  1  one-cycle pulse; starts a clear sweep.
- Busy  out  1  high while clearing.
- WrValid  in  1  write request.
- WrReady  out  1  write accepted when WrValid && WrReady.
- WrAccumulate  in  1  1 = add into row, 0 = overwrite row.
- WrSelector  in  VECTOR_SELECTOR_WIDTH  target row.
- Inputs  in  DATA_WIDTH x VECTOR_WIDTH  unpacked write data.
- RdValid  in  1  read request.
- RdReady  out  1  read accepted when RdValid && RdReady.
- RdSelector  in  VECTOR_SELECTOR_WIDTH  row to read.
- ResultValid  out  1  Result holds read data.
- Result  out  DATA_WIDTH x VECTOR_WIDTH  read data.

Behaviour:
- Reset: ASYNC_RST low forces Busy=1, WrReady=0, RdReady=0, ResultValid=0, Result lanes=0, the pipeline valid bit=0, the clear counter=0, and state=CLEAR.
- The storage array is not reset; it is zeroed by the CLEAR sweep.
- FSM states and transitions:
  - CLEAR writes 0 to row ClearCnt each cycle and increments ClearCnt.
  - CLEAR goes to IDLE after writing row NO_VECTORS-1, so a sweep takes exactly NO_VECTORS cycles.
  - IDLE accepts traffic. ClearReq in IDLE goes to DRAIN.
  - DRAIN waits until the pipeline stage is empty (at most 1 cycle), then goes to CLEAR with ClearCnt=0.
  - ClearReq while in CLEAR or DRAIN is ignored.
- Handshakes:
  - WrReady = RdReady = (state==IDLE) && !ClearReq.
  - Write acceptance does not depend on RdValid, and read acceptance does not depend on WrValid.
- Write pipeline:
  - At the accept edge N, the selector, mode and Inputs are registered into stage S1.
  - At edge N+1, S1 commits to the row:
    - overwrite: row = in
    - accumulate: row = old + in, lane-wise, DATA_WIDTH bits.
  - Back-to-back writes sustain 1 per cycle.
- Forwarding: if the S1 row equals the row being committed, the old operand is the committed value and not the stale array content. Required case: two consecutive accumulates to row R must both be counted.
- Read:
  - Accepted at edge N; Result and ResultValid=1 are registered at edge N.
  - ResultValid falls the cycle after the last accepted read.
  - Result holds its value when no read is accepted.
  - Read data reflects every write accepted strictly before the read's accept edge, including a write still in S1 (bypass).
  - A write accepted in the same cycle as the read is not visible to that read.
- Arithmetic wraps modulo 2^DATA_WIDTH, unless the optional feature below is compiled in.
- Reset mid-operation: a pending S1 write is lost, and a new sweep starts.

Optional Feature:
- Macro ACC_SATURATE_EN.
- Defined: an accumulate result that overflows clamps to the signed max (0x7FFF_FFFF at 32 bits) or the signed min (0x8000_0000). Sticky output SatFlag (1 bit) sets on any clamp and clears only on reset or on entering CLEAR.
- Undefined: the add wraps and the SatFlag port is absent.

Decomposition:
- Package accumulator_pkg:
  - typedef enum acc_state_e {IDLE, DRAIN, CLEAR}
  - localparam functions for signed max/min per DATA_WIDTH
  - typedef for the write-mode bit
- One sub-module, acc_lane_add: combinational DATA_WIDTH add with optional saturation and an overflow output. It is instantiated per lane inside a generate loop.

Test Plan:
- After reset release, Busy stays high for exactly NO_VECTORS=64 cycles. Then reading row 5 gives all lanes 0, with ResultValid on the next cycle.
- Overwrite row 3 with lane i = i, then accumulate row 3 with lane i = 10 on back-to-back cycles, then read row 3 -> lane i = i+10.
- Accumulate 1 into row 7 on 4 consecutive cycles, then read immediately -> all lanes 4, which checks forwarding plus read bypass.
- Write row 2 and read row 2 in the same cycle -> the read returns the old value; a read on the next cycle returns the new value.
- Pulse ClearReq while a write is in S1 -> that write commits, WrReady drops for 1+64 cycles, then all rows read 0.
- With ACC_SATURATE_EN: overwrite 0x7FFF_FFF0, then accumulate 0x20 -> result 0x7FFF_FFFF and SatFlag=1. Without the macro -> result 0x8000_0010.

Source files
------------

// File: rtl/accumulator_pkg.sv
// Shared types and constants for the accumulator bank: FSM states, write mode
// and signed saturation bounds derived from a lane width.
package accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } acc_state_e;

  typedef enum logic {
    WR_OVERWRITE  = 1'b0,
    WR_ACCUMULATE = 1'b1
  } wr_mode_e;

  localparam int unsigned MAX_DATA_WIDTH = 64;

  // Callers size-cast the result down to their own lane width.
  function automatic logic [MAX_DATA_WIDTH-1:0] signed_max(input int unsigned dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] signed_min(input int unsigned dw);
    return 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/acc_lane_add.sv
// One lane of the accumulate adder. With ACC_SATURATE_EN defined the sum clamps
// to the signed range and an overflow flag is exported; otherwise it wraps.
module acc_lane_add
  import accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_sum
`ifdef ACC_SATURATE_EN
  ,
  output logic                  o_ovf
`endif
);

  logic [DATA_WIDTH-1:0] w_raw;

  assign w_raw = i_a + i_b;

`ifdef ACC_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(signed_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(signed_min(DATA_WIDTH));

  // Signed overflow: operands agree in sign but the result does not.
  assign o_ovf = (i_a[DATA_WIDTH-1] == i_b[DATA_WIDTH-1]) &&
                 (w_raw[DATA_WIDTH-1] != i_a[DATA_WIDTH-1]);
  assign o_sum = !o_ovf ? w_raw : (i_a[DATA_WIDTH-1] ? SMIN : SMAX);
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/accumulator_bank.sv
// Row x lane accumulator storage with a 1-deep write pipeline, forwarding, a
// 1-cycle read port and a clear sweep FSM. ACC_SATURATE_EN enables clamping + SatFlag.
module accumulator_bank
  import accumulator_pkg::*;
#(
  parameter int VECTOR_WIDTH          = 16,
  parameter int NO_VECTORS            = 64,
  parameter int DATA_WIDTH            = 32,
  parameter int VECTOR_SELECTOR_WIDTH = $clog2(NO_VECTORS)
) (
  input  logic                             CLK,
  input  logic                             ASYNC_RST,
  input  logic                             ClearReq,
  output logic                             Busy,
  input  logic                             WrValid,
  output logic                             WrReady,
  input  logic                             WrAccumulate,
  input  logic [VECTOR_SELECTOR_WIDTH-1:0] WrSelector,
  input  logic [DATA_WIDTH-1:0]            Inputs [VECTOR_WIDTH],
  input  logic                             RdValid,
  output logic                             RdReady,
  input  logic [VECTOR_SELECTOR_WIDTH-1:0] RdSelector,
  output logic                             ResultValid,
  output logic [DATA_WIDTH-1:0]            Result [VECTOR_WIDTH],
`ifdef ACC_SATURATE_EN
  output logic                             SatFlag,
`endif
  output acc_state_e                       DbgState
);

  acc_state_e                       r_state;
  logic [VECTOR_SELECTOR_WIDTH-1:0] r_clear_cnt;

  logic                             r_s1_valid;
  logic [VECTOR_SELECTOR_WIDTH-1:0] r_s1_sel;
  wr_mode_e                         r_s1_mode;
  logic [DATA_WIDTH-1:0]            r_s1_data [VECTOR_WIDTH];
  logic [DATA_WIDTH-1:0]            r_s1_old  [VECTOR_WIDTH];

  logic [DATA_WIDTH-1:0]            r_mem [NO_VECTORS][VECTOR_WIDTH];

  logic [DATA_WIDTH-1:0]            w_sum     [VECTOR_WIDTH];
  logic [DATA_WIDTH-1:0]            w_commit  [VECTOR_WIDTH];
  logic [DATA_WIDTH-1:0]            w_old     [VECTOR_WIDTH];
  logic [DATA_WIDTH-1:0]            w_rd_data [VECTOR_WIDTH];
  logic                             w_open;
  logic                             w_wr_fire;
  logic                             w_rd_fire;
  logic                             w_wr_hit;
  logic                             w_rd_hit;
`ifdef ACC_SATURATE_EN
  logic [VECTOR_WIDTH-1:0]          w_ovf;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready; ready
  // depends only on the FSM and ClearReq, never on either valid, so the write
  // and read ports are accepted independently of each other.
  assign w_open    = (r_state == IDLE) && !ClearReq;
  assign WrReady   = w_open;
  assign RdReady   = w_open;
  assign w_wr_fire = WrValid && w_open;
  assign w_rd_fire = RdValid && w_open;
  assign Busy      = (r_state != IDLE);
  assign DbgState  = r_state;

  // The row committing this cycle supersedes the array for both new operands and reads.
  assign w_wr_hit = r_s1_valid && (r_s1_sel == WrSelector);
  assign w_rd_hit = r_s1_valid && (r_s1_sel == RdSelector);

  for (genvar g = 0; g < VECTOR_WIDTH; g++) begin : g_lane
    acc_lane_add #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_add (
      .i_a  (r_s1_old[g]),
      .i_b  (r_s1_data[g]),
      .o_sum(w_sum[g])
`ifdef ACC_SATURATE_EN
      ,
      .o_ovf(w_ovf[g])
`endif
    );

    assign w_commit[g]  = (r_s1_mode == WR_ACCUMULATE) ? w_sum[g] : r_s1_data[g];
    assign w_old[g]     = w_wr_hit ? w_commit[g] : r_mem[WrSelector][g];
    assign w_rd_data[g] = w_rd_hit ? w_commit[g] : r_mem[RdSelector][g];
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      r_state     <= CLEAR;
      r_clear_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ClearReq) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_s1_valid) begin
            r_state     <= CLEAR;
            r_clear_cnt <= '0;
          end
        end
        CLEAR: begin
          r_clear_cnt <= r_clear_cnt + 1'b1;
          if (r_clear_cnt == VECTOR_SELECTOR_WIDTH'(NO_VECTORS - 1)) r_state <= IDLE;
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_wr_fire;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_fire) begin
      r_s1_sel  <= WrSelector;
      r_s1_mode <= wr_mode_e'(WrAccumulate);
      r_s1_data <= Inputs;
      r_s1_old  <= w_old;
    end
  end

  // Storage has no reset; the CLEAR sweep is what zeroes it.
  always_ff @(posedge CLK) begin
    if (r_state == CLEAR) begin
      for (int l = 0; l < VECTOR_WIDTH; l++) r_mem[r_clear_cnt][l] <= '0;
    end else if (r_s1_valid) begin
      r_mem[r_s1_sel] <= w_commit;
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      ResultValid <= 1'b0;
      for (int l = 0; l < VECTOR_WIDTH; l++) Result[l] <= '0;
    end else begin
      ResultValid <= w_rd_fire;
      if (w_rd_fire) Result <= w_rd_data;
    end
  end

`ifdef ACC_SATURATE_EN
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      SatFlag <= 1'b0;
    end else if ((r_state == DRAIN) && !r_s1_valid) begin
      SatFlag <= 1'b0;
    end else if (r_s1_valid && (r_s1_mode == WR_ACCUMULATE) && (|w_ovf)) begin
      SatFlag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank: reference model of the row array,
// expected read rows queued on accept and compared when ResultValid appears.
module tb_accumulator_bank;
  import accumulator_pkg::*;

  localparam int VW = 16;
  localparam int NV = 64;
  localparam int DW = 32;
  localparam int SW = $clog2(NV);

  logic              clk;
  logic              rst_n;
  logic              clear_req;
  logic              busy;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_acc;
  logic [SW-1:0]     wr_sel;
  logic [DW-1:0]     in_arr [VW];
  logic              rd_valid;
  logic              rd_ready;
  logic [SW-1:0]     rd_sel;
  logic              res_valid;
  logic [DW-1:0]     res_arr [VW];
  acc_state_e        dbg_state;
`ifdef ACC_SATURATE_EN
  logic              sat_flag;
`endif

  accumulator_bank #(
    .VECTOR_WIDTH(VW),
    .NO_VECTORS  (NV),
    .DATA_WIDTH  (DW)
  ) dut (
    .CLK         (clk),
    .ASYNC_RST   (rst_n),
    .ClearReq    (clear_req),
    .Busy        (busy),
    .WrValid     (wr_valid),
    .WrReady     (wr_ready),
    .WrAccumulate(wr_acc),
    .WrSelector  (wr_sel),
    .Inputs      (in_arr),
    .RdValid     (rd_valid),
    .RdReady     (rd_ready),
    .RdSelector  (rd_sel),
    .ResultValid (res_valid),
    .Result      (res_arr),
`ifdef ACC_SATURATE_EN
    .SatFlag     (sat_flag),
`endif
    .DbgState    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int unsigned       n_checks = 0;
  int unsigned       n_fails  = 0;
  logic [DW*VW-1:0]  exp_q[$];
  logic [DW-1:0]     mdl [NV][VW];
  bit                rd_fire_exp = 1'b0;
  bit                exp_rv      = 1'b0;
  bit                mon_en      = 1'b0;
  bit                sat_exp     = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference lane add: sign-extended sum, clamped when saturation is built in.
  task automatic model_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] s);
    logic [DW:0] wide;
    wide = {a[DW-1], a} + {b[DW-1], b};
    s = wide[DW-1:0];
`ifdef ACC_SATURATE_EN
    if (wide[DW] != wide[DW-1]) begin
      s = wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      sat_exp = 1'b1;
    end
`endif
  endtask

  task automatic model_write(input bit acc, input int sel, input logic [DW*VW-1:0] row);
    logic [DW-1:0] s;
    for (int i = 0; i < VW; i++) begin
      if (acc) begin
        model_add(mdl[sel][i], row[i*DW +: DW], s);
        mdl[sel][i] = s;
      end else begin
        mdl[sel][i] = row[i*DW +: DW];
      end
    end
  endtask

  task automatic model_zero();
    for (int r = 0; r < NV; r++)
      for (int i = 0; i < VW; i++) mdl[r][i] = '0;
  endtask

  function automatic logic [DW*VW-1:0] model_row(input int sel);
    logic [DW*VW-1:0] r;
    for (int i = 0; i < VW; i++) r[i*DW +: DW] = mdl[sel][i];
    return r;
  endfunction

  function automatic logic [DW*VW-1:0] mk_row(input logic [DW-1:0] base, input bit ramp);
    logic [DW*VW-1:0] r;
    for (int i = 0; i < VW; i++) r[i*DW +: DW] = base + (ramp ? DW'(i) : '0);
    return r;
  endfunction

  function automatic logic [DW*VW-1:0] rand_row();
    logic [DW*VW-1:0] r;
    for (int i = 0; i < VW; i++) r[i*DW +: DW] = $urandom();
    return r;
  endfunction

  // ---------------- driver tasks (called just after a falling edge) ----------------
  task automatic do_cycle(input bit wv, input bit wa, input int wsel, input logic [DW*VW-1:0] wrow,
                          input bit rv, input int rsel, input bit cr);
    wr_valid  = wv;
    wr_acc    = wa;
    wr_sel    = SW'(wsel);
    for (int i = 0; i < VW; i++) in_arr[i] = wrow[i*DW +: DW];
    rd_valid  = rv;
    rd_sel    = SW'(rsel);
    clear_req = cr;
    #1;
    if (wv) check_eq("wr_ready", {63'd0, wr_ready}, {63'd0, !cr});
    if (rv) check_eq("rd_ready", {63'd0, rd_ready}, {63'd0, !cr});
    rd_fire_exp = rv && !cr;
    // Read sees only writes accepted before it, so snapshot before applying this write.
    if (rd_fire_exp) exp_q.push_back(model_row(rsel));
    if (wv && !cr) model_write(wa, wsel, wrow);
    @(posedge clk);
    @(negedge clk);
    wr_valid    = 1'b0;
    rd_valid    = 1'b0;
    clear_req   = 1'b0;
    rd_fire_exp = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Counts falling-edge samples with Busy high; optionally pokes ClearReq mid-sweep.
  task automatic wait_sweep(input string tag, input int exp_cycles, input bit poke);
    int cnt;
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      clear_req = poke && (cnt == 10);
      @(posedge clk);
      @(negedge clk);
    end
    clear_req = 1'b0;
    check_eq(tag, cnt, exp_cycles);
    check_eq({tag, "_idle"}, {62'd0, dbg_state}, {62'd0, IDLE});
  endtask

  task automatic apply_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    rd_valid  = 1'b0;
    clear_req = 1'b0;
    idle(3);
    model_zero();
    sat_exp = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) exp_rv <= rd_fire_exp;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [DW*VW-1:0] e;
      check_eq("result_valid", {63'd0, res_valid}, {63'd0, exp_rv});
      if (res_valid) begin
        check_eq("rq_nonempty", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int i = 0; i < VW; i++) check_eq("result_lane", res_arr[i], e[i*DW +: DW]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    wr_acc = 1'b0;
    wr_sel = '0;
    rd_sel = '0;
    for (int i = 0; i < VW; i++) in_arr[i] = '0;
    apply_reset();

    check_eq("rst_busy", {63'd0, busy}, 64'd1);
    check_eq("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    check_eq("rst_rd_ready", {63'd0, rd_ready}, 64'd0);
    check_eq("rst_result_valid", {63'd0, res_valid}, 64'd0);
    for (int i = 0; i < VW; i++) check_eq("rst_result", res_arr[i], 64'd0);

    rst_n = 1'b1;
    wait_sweep("reset_sweep", NV, 1'b0);
    mon_en = 1'b1;
`ifdef ACC_SATURATE_EN
    check_eq("sat_after_reset", {63'd0, sat_flag}, 64'd0);
`endif

    // Freshly cleared row.
    do_cycle(0, 0, 0, '0, 1, 5, 0);
    idle(1);

    // Overwrite ramp then accumulate 10, read while the accumulate is still in flight.
    do_cycle(1, 0, 3, mk_row(0, 1), 0, 0, 0);
    do_cycle(1, 1, 3, mk_row(10, 0), 0, 0, 0);
    do_cycle(0, 0, 0, '0, 1, 3, 0);
    idle(1);

    // Four back-to-back accumulates into the same row, read immediately after.
    for (int k = 0; k < 4; k++) do_cycle(1, 1, 7, mk_row(1, 0), 0, 0, 0);
    do_cycle(0, 0, 0, '0, 1, 7, 0);
    idle(1);

    // Same-cycle write and read of row 2, then a follow-up read.
    do_cycle(1, 0, 2, mk_row(32'h55, 1), 1, 2, 0);
    do_cycle(0, 0, 0, '0, 1, 2, 0);
    idle(2);

    // Random mixed traffic over a small row set to stress forwarding and bypass.
    for (int k = 0; k < 200; k++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
               rand_row(), 1'($urandom_range(0, 1)), $urandom_range(0, 7), 0);
    end
    idle(2);
`ifdef ACC_SATURATE_EN
    check_eq("sat_after_random", {63'd0, sat_flag}, {63'd0, sat_exp});
`endif

    // Clear request while a write sits in S1; a write offered with the request is refused.
    do_cycle(1, 0, 4, mk_row(32'hABC, 1), 0, 0, 0);
    do_cycle(1, 0, 6, mk_row(32'h123, 0), 0, 0, 1);
    wait_sweep("clear_sweep", NV + 1, 1'b1);
    model_zero();
    sat_exp = 1'b0;
`ifdef ACC_SATURATE_EN
    check_eq("sat_after_clear", {63'd0, sat_flag}, 64'd0);
`endif
    for (int r = 0; r < NV; r++) do_cycle(0, 0, 0, '0, 1, r, 0);
    idle(2);

    // Positive and negative overflow on accumulate.
    do_cycle(1, 0, 9, mk_row(32'h7FFF_FFF0, 0), 0, 0, 0);
    do_cycle(1, 1, 9, mk_row(32'h0000_0020, 0), 0, 0, 0);
    do_cycle(1, 0, 10, mk_row(32'h8000_0010, 0), 1, 9, 0);
    do_cycle(1, 1, 10, mk_row(32'hFFFF_FFE0, 0), 0, 0, 0);
    do_cycle(0, 0, 0, '0, 1, 10, 0);
    idle(2);
`ifdef ACC_SATURATE_EN
    check_eq("sat_after_clamp", {63'd0, sat_flag}, 64'd1);
`endif

    // Reset with a write pending in S1: a fresh sweep must run and rows read zero.
    do_cycle(1, 0, 1, mk_row(32'hDEAD, 1), 0, 0, 0);
    apply_reset();
    check_eq("midrst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b1;
    wait_sweep("midrst_sweep", NV, 1'b0);
    mon_en = 1'b1;
    do_cycle(0, 0, 0, '0, 1, 1, 0);
    do_cycle(0, 0, 0, '0, 1, 3, 0);
    idle(3);

    check_eq("rq_drained", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
